conv_mac_accumulator: RTL and testbench
=======================================

CONV_MAC_ACCUMULATOR -- requirements
Module: conv_mac_accumulator

Interface
REQ-001 Parameter Data_Width, default 16, signed Q8.8 width of pixel and weight operands.
REQ-002 Parameter Frac_Bits, default 8, fractional bits of operands, bias and result.
REQ-003 Parameter Acc_Width, default 40, signed accumulator width.
REQ-004 Parameter Out_Width, default 16, signed result width; sized to drive Register Data_in at Data_Width = 16.
REQ-005 Parameter Taps, default 25, number of products per result (5x5 kernel).
REQ-006 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- Start  in  1  begin a new result; sampled in IDLE only.
- Bias_in  in  Out_Width  signed bias, Q format with Frac_Bits fractional bits; sampled with Start.
- Pixel_in  in  Data_Width  signed operand.
- Weight_in  in  Data_Width  signed operand.
- In_valid  in  1  Pixel_in/Weight_in valid.
- In_ready  out  1  block accepts a beat.
- Busy  out  1  high in any state other than IDLE.
- Data_out  out  Out_Width  saturated result; intended to drive Register Data_in.
- Out_valid  out  1  one-cycle pulse, Data_out new; intended to drive Register Enable.
- Overflow  out  1  result was clamped; valid with Out_valid.

Function
REQ-007 FSM states: IDLE, ACCUM, DRAIN, DONE.
REQ-008 IDLE -> ACCUM on Start; accumulator loaded with sign-extended Bias_in << Frac_Bits; beat counter cleared.
REQ-009 A beat is accepted on a rising edge where In_valid && In_ready.
REQ-010 In_ready is high only in ACCUM with beat count < Taps; it is low in IDLE, DRAIN and DONE.
REQ-011 Stage 1 registers the full-precision product Pixel_in*Weight_in (2*Data_Width bits) together with a valid bit; stage 2 adds the sign-extended product to the accumulator.
REQ-012 ACCUM -> DRAIN on the edge that accepts beat number Taps; DRAIN lasts until the stage-1 and stage-2 valids are empty.
REQ-013 DRAIN -> DONE: result = accumulator >>> Frac_Bits (arithmetic), clamped to [-2^(Out_Width-1), 2^(Out_Width-1)-1].
REQ-014 Data_out, Overflow and Out_valid are registered; Out_valid rises on the 3rd rising edge after the edge accepting the final beat.
REQ-015 DONE lasts one cycle, then returns to IDLE; Out_valid is high for exactly one cycle.
REQ-016 Data_out and Overflow hold their values until the next result.
REQ-017 Gaps in In_valid stall accumulation without loss; the result is independent of gap pattern.
REQ-018 Start outside IDLE is ignored; a Start in the same cycle as DONE is also ignored.
REQ-019 No beat is accepted in the Start cycle.
REQ-020 Overflow = 1 only when the clamp in REQ-013 changed the value.

Reset
REQ-021 When reset is high at a rising edge: state = IDLE; accumulator, counter and pipeline valids are cleared; Data_out = 0; Out_valid = 0; Overflow = 0.
REQ-022 Reset outputs: In_ready = 0, Busy = 0.
REQ-023 Reset mid-operation aborts the result and discards partial sums; no Out_valid is produced for the aborted frame.
REQ-024 Reset has priority over all other inputs.

Structure
REQ-025 The shared package lenet_pkg holds:
- constants DATA_WIDTH = 16, FRAC_BITS = 8, KERNEL_TAPS = 25;
- the FSM state typedef.
REQ-026 The shift-and-saturate logic is one combinational sub-module, saturate_shift (in: Acc_Width; out: Out_Width plus overflow flag).
REQ-027 The beat counter width is clog2(Taps+1).

Verification
REQ-028 Start with Bias_in = 0x0000; 25 beats Pixel = Weight = 0x0100 back-to-back -> Data_out = 0x1900, Overflow = 0, Out_valid 3 cycles after the last beat.
REQ-029 Same inputs with Bias_in = 0x0100 and random In_valid gaps -> Data_out = 0x1A00; In_ready drops after beat 25.
REQ-030 25 beats Pixel = Weight = 0x7FFF -> Data_out = 0x7FFF, Overflow = 1; 25 beats Pixel = 0x8000, Weight = 0x7FFF -> Data_out = 0x8000, Overflow = 1.
REQ-031 Reset asserted for 1 cycle after beat 10 -> no Out_valid; a following full frame of REQ-028 stimulus -> 0x1900.
REQ-032 Start pulsed during ACCUM and in the DONE cycle -> ignored; exactly one Out_valid per accepted Start; Data_out held between results.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and FSM state encoding for the LeNet convolution datapath.
package lenet_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRAC_BITS   = 8;
    localparam int KERNEL_TAPS = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/saturate_shift.sv
// Drops the fractional scaling of a wide accumulator and clamps it into the
// signed result range, flagging when the clamp altered the value.
module saturate_shift
    import lenet_pkg::*;
#(
    parameter int Acc_Width = 40,
    parameter int Out_Width = 16,
    parameter int Frac_Bits = FRAC_BITS
) (
    input  logic signed [Acc_Width-1:0] acc_in,
    output logic signed [Out_Width-1:0] data_out,
    output logic                        overflow
);

    localparam logic signed [Acc_Width-1:0] SAT_MAX =
        {{(Acc_Width-Out_Width+1){1'b0}}, {(Out_Width-1){1'b1}}};
    localparam logic signed [Acc_Width-1:0] SAT_MIN =
        {{(Acc_Width-Out_Width+1){1'b1}}, {(Out_Width-1){1'b0}}};

    // Returns {overflow, value}: arithmetic shift then clamp to the output range.
    function automatic logic [Out_Width:0] shift_sat(input logic signed [Acc_Width-1:0] a);
        logic signed [Acc_Width-1:0] s;
        s = a >>> Frac_Bits;
        if (s > SAT_MAX) begin
            return {1'b1, SAT_MAX[Out_Width-1:0]};
        end else if (s < SAT_MIN) begin
            return {1'b1, SAT_MIN[Out_Width-1:0]};
        end else begin
            return {1'b0, s[Out_Width-1:0]};
        end
    endfunction

    assign {overflow, data_out} = shift_sat(acc_in);

endmodule

// File: rtl/conv_mac_accumulator.sv
// Two-stage multiply-accumulate for one convolution output: multiply, then
// accumulate Taps products onto a bias, then shift/saturate into Data_out.
module conv_mac_accumulator
    import lenet_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH,
    parameter int Frac_Bits  = FRAC_BITS,
    parameter int Acc_Width  = 40,
    parameter int Out_Width  = 16,
    parameter int Taps       = KERNEL_TAPS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Start,
    input  logic signed [Out_Width-1:0]  Bias_in,
    input  logic signed [Data_Width-1:0] Pixel_in,
    input  logic signed [Data_Width-1:0] Weight_in,
    input  logic                         In_valid,
    output logic                         In_ready,
    output logic                         Busy,
    output logic signed [Out_Width-1:0]  Data_out,
    output logic                         Out_valid,
    output logic                         Overflow
);

    localparam int CNT_W  = $clog2(Taps + 1);
    localparam int PROD_W = 2 * Data_Width;

    state_t                     state_q,     state_d;
    logic [CNT_W-1:0]           cnt_q,       cnt_d;
    logic signed [Acc_Width-1:0] acc_q,      acc_d;
    logic signed [PROD_W-1:0]   prod_p1_q,   prod_p1_d;
    logic                       vld_p1_q,    vld_p1_d;
    logic                       vld_p2_q,    vld_p2_d;
    logic signed [Out_Width-1:0] data_out_q, data_out_d;
    logic                       ovf_q,       ovf_d;
    logic                       out_valid_q, out_valid_d;

    logic                        beat_acc;
    logic signed [Acc_Width-1:0] prod_ext;
    logic signed [Acc_Width-1:0] bias_ext;
    logic signed [Out_Width-1:0] sat_data;
    logic                        sat_ovf;

    assign In_ready  = (state_q == ACCUM) && (cnt_q < CNT_W'(Taps));
    assign Busy      = (state_q != IDLE);
    assign beat_acc  = In_valid && In_ready;
    assign prod_ext  = {{(Acc_Width-PROD_W){prod_p1_q[PROD_W-1]}}, prod_p1_q};
    assign bias_ext  = {{(Acc_Width-Out_Width-Frac_Bits){Bias_in[Out_Width-1]}},
                        Bias_in, {Frac_Bits{1'b0}}};
    assign Data_out  = data_out_q;
    assign Overflow  = ovf_q;
    assign Out_valid = out_valid_q;

    saturate_shift #(
        .Acc_Width (Acc_Width),
        .Out_Width (Out_Width),
        .Frac_Bits (Frac_Bits)
    ) u_sat (
        .acc_in   (acc_q),
        .data_out (sat_data),
        .overflow (sat_ovf)
    );

    // Next-state, pipeline advance and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        // stage 1: full-precision product of the accepted beat
        prod_p1_d   = Pixel_in * Weight_in;
        vld_p1_d    = beat_acc;
        // stage 2: accumulate the stage-1 product
        vld_p2_d    = vld_p1_q;
        data_out_d  = data_out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        if (vld_p1_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = ACCUM;
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(Taps - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d     = DONE;
                    data_out_d  = sat_data;
                    ovf_d       = sat_ovf;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, accumulator and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            data_out_q  <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            data_out_q  <= data_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Product register; qualified by vld_p1_q so it needs no reset.
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
    end

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Directed bench for conv_mac_accumulator: basic frames, gaps, saturation,
// mid-frame reset and ignored Start pulses.
module tb_conv_mac_accumulator;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [15:0] Bias_in;
    logic [15:0] Pixel_in;
    logic [15:0] Weight_in;
    logic        In_valid;
    logic        In_ready;
    logic        Busy;
    logic [15:0] Data_out;
    logic        Out_valid;
    logic        Overflow;

    int n_pass;
    int n_total;

    conv_mac_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Bias_in   (Bias_in),
        .Pixel_in  (Pixel_in),
        .Weight_in (Weight_in),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Busy      (Busy),
        .Data_out  (Data_out),
        .Out_valid (Out_valid),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full frame of Taps beats, with optional gaps and ignored Start pulses.
    task automatic run_frame(input string tag, input logic [15:0] bias,
                             input logic [15:0] pix, input logic [15:0] wgt,
                             input bit gaps, input bit mid_start, input bit done_start,
                             input logic [15:0] exp_data, input bit exp_ovf);
        int lat;
        int extra;
        bit rdy_ok;
        Start = 1'b1; Bias_in = bias;
        In_valid = 1'b1; Pixel_in = 16'h7000; Weight_in = 16'h7000;
        tick();
        Start = 1'b0; Bias_in = 16'h0000;
        rdy_ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                In_valid = 1'b0;
                tick();
            end
            In_valid = 1'b1; Pixel_in = pix; Weight_in = wgt;
            if (mid_start && i == 5) begin
                Start = 1'b1; Bias_in = 16'h7F00;
            end
            if (In_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
            Start = 1'b0; Bias_in = 16'h0000;
        end
        In_valid = 1'b0;
        check({tag, "_ready_during"}, 64'(rdy_ok), 64'd1);
        check({tag, "_ready_after"}, 64'(In_ready), 64'd0);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            if (Out_valid === 1'b1) lat = c;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_data"}, 64'(Data_out), 64'(exp_data));
        check({tag, "_ovf"}, 64'(Overflow), 64'(exp_ovf));
        if (done_start) begin
            Start = 1'b1; Bias_in = 16'h1234;
        end
        tick();
        Start = 1'b0; Bias_in = 16'h0000;
        check({tag, "_pulse_end"}, 64'(Out_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (Out_valid !== 1'b0) extra++;
        end
        check({tag, "_no_extra_valid"}, 64'(extra), 64'd0);
        check({tag, "_data_held"}, 64'(Data_out), 64'(exp_data));
        check({tag, "_ovf_held"}, 64'(Overflow), 64'(exp_ovf));
    endtask

    initial begin
        int seen;
        n_pass = 0; n_total = 0;
        reset = 1'b1; Start = 1'b0; Bias_in = '0;
        Pixel_in = '0; Weight_in = '0; In_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_ready", 64'(In_ready), 64'd0);
        check("rst_out_valid", 64'(Out_valid), 64'd0);
        check("rst_data", 64'(Data_out), 64'd0);
        check("rst_ovf", 64'(Overflow), 64'd0);

        // unit products, zero bias: 25 * 1.0 = 25.0
        run_frame("unit", 16'h0000, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h1900, 1'b0);
        // bias 1.0 with gaps: 26.0
        run_frame("gaps", 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h1A00, 1'b0);
        // positive and negative saturation
        run_frame("satp", 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1);
        run_frame("satn", 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1);

        // reset after beat 10 aborts the frame
        Start = 1'b1; Bias_in = 16'h0000;
        tick();
        Start = 1'b0;
        In_valid = 1'b1; Pixel_in = 16'h0100; Weight_in = 16'h0100;
        for (int i = 0; i < 10; i++) tick();
        In_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_ready", 64'(In_ready), 64'd0);
        check("abort_data", 64'(Data_out), 64'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (Out_valid !== 1'b0) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        run_frame("after_abort", 16'h0000, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h1900, 1'b0);

        // Start pulses in ACCUM and in the DONE cycle are ignored
        run_frame("ign_start", 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h1A00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
